// File: rtl/sketch_counter_dump.sv
// Sketch counter bank: saturating per-counter accumulation, with a slice-major
// clear-on-read dump streamed one registered word per cycle.
module sketch_counter_dump #(
  parameter int NUM_COUNTER = 10,
  parameter int NUM_SLICE   = 3,
  parameter int INC_WIDTH   = 16
) (
  input  logic                 SYS_CLK,
  input  logic                 RESET,
  input  logic                 Upd_valid,
  input  logic [7:0]           Upd_slice,
  input  logic [15:0]          Upd_index,
  input  logic [INC_WIDTH-1:0] Upd_inc,
  output logic                 Upd_ready,
  input  logic                 Dump_req,
  output logic [31:0]          Counter,
  output logic                 Counter_valid,
  output logic                 Slice_last,
  output logic                 Dump_done,
  output logic                 Upd_err
);

  localparam int DATA_W = 32;
  localparam int TOTAL  = NUM_SLICE * NUM_COUNTER;
  localparam int IDX_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int POS_W  = (NUM_COUNTER > 1) ? $clog2(NUM_COUNTER) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_COUNTER - 1);

  typedef enum logic {IDLE, DUMP} state_t;

  state_t              state_q, state_d;
  logic                armed_q, armed_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [DATA_W-1:0]   cnt_q [TOTAL];
  logic [DATA_W-1:0]   cnt_d [TOTAL];
  logic [DATA_W-1:0]   counter_q, counter_d;
  logic                valid_q, valid_d;
  logic                slice_last_q, slice_last_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                accept;
  logic                in_range;
  logic                loading;
  logic [IDX_W-1:0]    rd_idx;
  logic [POS_W-1:0]    rd_pos;

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0]    a,
                                                input logic [INC_WIDTH-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + (DATA_W + 1)'(b);
    return sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
  endfunction

  // Ready only once out of reset (armed) and not streaming.
  assign Upd_ready = (state_q == IDLE) && armed_q;
  assign accept    = Upd_valid && Upd_ready;
  assign in_range  = (32'(Upd_slice) < NUM_SLICE) && (32'(Upd_index) < NUM_COUNTER);
  assign loading   = (state_q == DUMP) || Dump_req;
  assign rd_idx    = (state_q == IDLE) ? '0 : idx_q;
  assign rd_pos    = (state_q == IDLE) ? '0 : pos_q;

  always_comb begin
    state_d      = state_q;
    armed_d      = 1'b1;
    idx_d        = idx_q;
    pos_d        = pos_q;
    counter_d    = '0;
    valid_d      = 1'b0;
    slice_last_d = 1'b0;
    done_d       = 1'b0;
    err_d        = accept && !in_range;

    for (int s = 0; s < NUM_SLICE; s++) begin
      for (int c = 0; c < NUM_COUNTER; c++) begin
        cnt_d[s*NUM_COUNTER + c] = cnt_q[s*NUM_COUNTER + c];
        if (accept && in_range && (Upd_slice == 8'(s)) && (Upd_index == 16'(c)))
          cnt_d[s*NUM_COUNTER + c] = sat_add(cnt_q[s*NUM_COUNTER + c], Upd_inc);
      end
    end

    // The word read sees any same-cycle update, then the counter is cleared.
    if (loading) begin
      for (int k = 0; k < TOTAL; k++) begin
        if (IDX_W'(k) == rd_idx) begin
          counter_d = cnt_d[k];
          cnt_d[k]  = '0;
        end
      end
      valid_d      = 1'b1;
      slice_last_d = (rd_pos == LAST_POS);
      done_d       = (rd_idx == LAST_IDX);
      pos_d        = (rd_pos == LAST_POS) ? '0 : rd_pos + POS_W'(1);
      if (rd_idx == LAST_IDX) begin
        idx_d   = '0;
        state_d = IDLE;
      end else begin
        idx_d   = rd_idx + IDX_W'(1);
        state_d = DUMP;
      end
    end
  end

  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      armed_q      <= 1'b0;
      idx_q        <= '0;
      pos_q        <= '0;
      counter_q    <= '0;
      valid_q      <= 1'b0;
      slice_last_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      for (int k = 0; k < TOTAL; k++) cnt_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      idx_q        <= idx_d;
      pos_q        <= pos_d;
      counter_q    <= counter_d;
      valid_q      <= valid_d;
      slice_last_q <= slice_last_d;
      done_q       <= done_d;
      err_q        <= err_d;
      for (int k = 0; k < TOTAL; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign Counter       = counter_q;
  assign Counter_valid = valid_q;
  assign Slice_last    = slice_last_q;
  assign Dump_done     = done_q;
  assign Upd_err       = err_q;

endmodule

// File: tb/tb_sketch_counter_dump.sv
// Directed bench for sketch_counter_dump: updates, saturation, range errors,
// clear-on-read dumps, chained dumps and reset abort.
module tb_sketch_counter_dump;

  localparam int NC    = 10;
  localparam int NS    = 3;
  localparam int TOTAL = NC * NS;

  logic        SYS_CLK = 1'b0;
  logic        RESET;
  logic        Upd_valid;
  logic [7:0]  Upd_slice;
  logic [15:0] Upd_index;
  logic [15:0] Upd_inc;
  logic        Upd_ready;
  logic        Dump_req;
  logic [31:0] Counter;
  logic        Counter_valid;
  logic        Slice_last;
  logic        Dump_done;
  logic        Upd_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_w [TOTAL];

  sketch_counter_dump #(.NUM_COUNTER(NC), .NUM_SLICE(NS), .INC_WIDTH(16)) dut (
    .SYS_CLK      (SYS_CLK),
    .RESET        (RESET),
    .Upd_valid    (Upd_valid),
    .Upd_slice    (Upd_slice),
    .Upd_index    (Upd_index),
    .Upd_inc      (Upd_inc),
    .Upd_ready    (Upd_ready),
    .Dump_req     (Dump_req),
    .Counter      (Counter),
    .Counter_valid(Counter_valid),
    .Slice_last   (Slice_last),
    .Dump_done    (Dump_done),
    .Upd_err      (Upd_err)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic clear_exp();
    for (int k = 0; k < TOTAL; k++) exp_w[k] = '0;
  endtask

  task automatic upd(input int s, input int i, input int inc, input bit exp_err);
    Upd_valid = 1'b1;
    Upd_slice = 8'(s);
    Upd_index = 16'(i);
    Upd_inc   = 16'(inc);
    tick();
    Upd_valid = 1'b0;
    chk($sformatf("upd_err(%0d,%0d)", s, i), 32'(Upd_err), 32'(exp_err));
  endtask

  // Expects the first word already loaded; checks all words against exp_w.
  task automatic dump_words(input bit chain);
    for (int w = 0; w < TOTAL; w++) begin
      if (w == 5) Dump_req = 1'b1;
      if (w == 6) Dump_req = 1'b0;
      if (w == TOTAL - 1) begin
        Upd_valid = 1'b0;
        if (chain) Dump_req = 1'b1;
      end
      chk($sformatf("word%0d", w),       Counter,             exp_w[w]);
      chk($sformatf("valid%0d", w),      32'(Counter_valid),  32'd1);
      chk($sformatf("slice_last%0d", w), 32'(Slice_last),     32'(w % NC == NC - 1));
      chk($sformatf("done%0d", w),       32'(Dump_done),      32'(w == TOTAL - 1));
      chk($sformatf("ready%0d", w),      32'(Upd_ready),      32'(w == TOTAL - 1));
      tick();
    end
    Dump_req = 1'b0;
    if (!chain) begin
      chk("post_valid",   32'(Counter_valid), 32'd0);
      chk("post_counter", Counter,            32'd0);
      chk("post_done",    32'(Dump_done),     32'd0);
      chk("post_ready",   32'(Upd_ready),     32'd1);
    end
  endtask

  task automatic run_dump(input bit chain);
    Dump_req = 1'b1;
    tick();
    Dump_req = 1'b0;
    dump_words(chain);
  endtask

  initial begin
    RESET     = 1'b1;
    Upd_valid = 1'b0;
    Upd_slice = '0;
    Upd_index = '0;
    Upd_inc   = '0;
    Dump_req  = 1'b0;
    tick();
    chk("rst_counter", Counter,             32'd0);
    chk("rst_valid",   32'(Counter_valid),  32'd0);
    chk("rst_slast",   32'(Slice_last),     32'd0);
    chk("rst_done",    32'(Dump_done),      32'd0);
    chk("rst_err",     32'(Upd_err),        32'd0);
    chk("rst_ready",   32'(Upd_ready),      32'd0);
    RESET = 1'b0;
    #1;
    chk("ready_before_edge", 32'(Upd_ready), 32'd0);
    tick();
    chk("ready_after_edge",  32'(Upd_ready), 32'd1);

    // Basic accumulation and slice-major order
    upd(0, 2, 5, 1'b0);
    upd(0, 2, 7, 1'b0);
    upd(2, 9, 100, 1'b0);
    clear_exp();
    exp_w[2]  = 32'd12;
    exp_w[29] = 32'd100;
    run_dump(1'b0);

    // Clear-on-read: nothing updated since
    clear_exp();
    run_dump(1'b0);

    // Saturation: (1,0) to FFFF_FFF0 then +FFFF; (1,1) plain carry
    Upd_valid = 1'b1;
    Upd_slice = 8'd1;
    Upd_index = 16'd0;
    Upd_inc   = 16'hFFFF;
    repeat (65536) @(posedge SYS_CLK);
    #1;
    Upd_inc = 16'hFFF0;
    tick();
    Upd_inc = 16'hFFFF;
    tick();
    Upd_index = 16'd1;
    tick();
    tick();
    Upd_valid = 1'b0;
    chk("sat_err", 32'(Upd_err), 32'd0);
    clear_exp();
    exp_w[10] = 32'hFFFF_FFFF;
    exp_w[11] = 32'h0001_FFFE;
    run_dump(1'b0);

    // Out-of-range updates
    upd(3, 0, 1, 1'b1);
    tick();
    chk("err_pulse_end_a", 32'(Upd_err), 32'd0);
    upd(0, 10, 1, 1'b1);
    tick();
    chk("err_pulse_end_b", 32'(Upd_err), 32'd0);
    clear_exp();
    run_dump(1'b0);

    // Update coincident with Dump_req is included; updates during dump dropped
    Upd_valid = 1'b1;
    Upd_slice = 8'd1;
    Upd_index = 16'd4;
    Upd_inc   = 16'd3;
    clear_exp();
    exp_w[14] = 32'd3;
    run_dump(1'b0);
    clear_exp();
    run_dump(1'b0);

    // Back-to-back dumps
    upd(0, 0, 1, 1'b0);
    upd(2, 9, 2, 1'b0);
    clear_exp();
    exp_w[0]  = 32'd1;
    exp_w[29] = 32'd2;
    run_dump(1'b1);
    clear_exp();
    dump_words(1'b0);

    // Reset in the middle of a dump
    upd(0, 5, 9, 1'b0);
    upd(2, 5, 9, 1'b0);
    Dump_req = 1'b1;
    tick();
    Dump_req = 1'b0;
    repeat (5) tick();
    chk("pre_abort_word5", Counter, 32'd9);
    RESET = 1'b1;
    #1;
    chk("abort_valid",   32'(Counter_valid), 32'd0);
    chk("abort_counter", Counter,            32'd0);
    chk("abort_ready",   32'(Upd_ready),     32'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("abort_done%0d", c),  32'(Dump_done),     32'd0);
      chk($sformatf("abort_valid%0d", c), 32'(Counter_valid), 32'd0);
    end
    RESET = 1'b0;
    #1;
    chk("rel_ready_before", 32'(Upd_ready), 32'd0);
    tick();
    chk("rel_ready_after",  32'(Upd_ready), 32'd1);
    chk("rel_done",         32'(Dump_done), 32'd0);
    clear_exp();
    run_dump(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
